// File: rtl/hex_ascii_streamer.sv
// ---------------------------------------------------------------------------
// hex_ascii_streamer
//
// Takes a DATA_W-bit result over a valid/ready handshake and streams it to
// the UART TX stage as hex ASCII characters, most significant nibble first.
// Leading zero nibbles can be dropped per frame (suppress_lz, sampled at
// accept). The final nibble is always sent, so a zero result still yields "0".
//
// Optional feature (compile-time macro HEX_ASCII_STREAMER_CRLF_EN):
//   defined   - a CR (0x0D) then LF (0x0A) follow the last digit, and done
//               fires after the LF is accepted.
//   undefined - no terminator; done fires after the last digit is accepted.
//
// Parameters:
//   DATA_W     result width, multiple of 4, 4..64
//   LOWER_CASE 0: A-F -> 0x41-0x46, 1: a-f -> 0x61-0x66
//
// Ports:
//   clk          clock
//   n_rst        asynchronous active-low reset
//   res_valid    result available
//   res_data     result value (DATA_W bits)
//   res_ready    block can accept a result (high only in IDLE)
//   suppress_lz  drop leading zero nibbles for the accepted result
//   tx_valid     character valid toward the UART TX stage
//   tx_data      ASCII character
//   tx_ready     UART TX stage accepts the character
//   busy         a frame is in progress
//   done         one-cycle pulse after the last character is accepted
//
// Every output is a register, so there is no combinational path from any
// input to any output.
// ---------------------------------------------------------------------------
module hex_ascii_streamer #(
  parameter int DATA_W     = 32,
  parameter int LOWER_CASE = 0
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready,
  input  logic              suppress_lz,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam int NIB   = DATA_W / 4;
  localparam int CNT_W = $clog2(NIB + 1);

  typedef enum logic [2:0] {
    IDLE,
    SKIP,
    SEND,
`ifdef HEX_ASCII_STREAMER_CRLF_EN
    TERM,
`endif
    DONE
  } state_e;

  state_e             state_q;
  logic [DATA_W-1:0]  shift_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               res_ready_q;
  logic               tx_valid_q;
  logic [7:0]         tx_data_q;
  logic               busy_q;
  logic               done_q;

  // Values the shift register and digit counter take when one nibble is
  // consumed (skipped or transmitted).
  logic [DATA_W-1:0]  shift_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [3:0]         top_nib;
  logic [3:0]         next_nib;

  assign shift_d  = shift_q << 4;
  assign cnt_d    = cnt_q - CNT_W'(1);
  assign top_nib  = shift_q[DATA_W-1 -: 4];
  assign next_nib = shift_d[DATA_W-1 -: 4];

  function automatic logic [7:0] to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    // Letter base minus 10, so nibble 10 lands on 'A' or 'a'.
    return {4'h0, nib} + ((LOWER_CASE != 0) ? 8'h57 : 8'h37);
  endfunction

  // NOTE: all state, including the data-path shift register, is updated
  // with non-blocking assignments in this one clocked block so every read
  // sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      res_ready_q <= 1'b1;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (res_valid && res_ready_q) begin
            shift_q     <= res_data;
            cnt_q       <= CNT_W'(NIB);
            res_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            // suppress_lz only matters here; the choice of next state
            // carries it for the rest of the frame.
            if (suppress_lz) begin
              state_q <= SKIP;
            end else begin
              state_q    <= SEND;
              tx_valid_q <= 1'b1;
              tx_data_q  <= to_ascii(res_data[DATA_W-1 -: 4]);
            end
          end
        end

        SKIP: begin
          // cnt_q > 1 keeps the final nibble, so zero still prints "0".
          if (top_nib == 4'h0 && cnt_q > CNT_W'(1)) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
          end else begin
            state_q    <= SEND;
            tx_valid_q <= 1'b1;
            tx_data_q  <= to_ascii(top_nib);
          end
        end

        SEND: begin
          // tx_valid_q is always high here, so tx_ready alone completes the
          // handshake; tx_data_q only changes on a handshake.
          if (tx_ready) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            if (cnt_q == CNT_W'(1)) begin
`ifdef HEX_ASCII_STREAMER_CRLF_EN
              state_q   <= TERM;
              tx_data_q <= 8'h0D;
`else
              state_q    <= DONE;
              tx_valid_q <= 1'b0;
              done_q     <= 1'b1;
`endif
            end else begin
              tx_data_q <= to_ascii(next_nib);
            end
          end
        end

`ifdef HEX_ASCII_STREAMER_CRLF_EN
        TERM: begin
          // The presented character itself tells CR from LF.
          if (tx_ready) begin
            if (tx_data_q == 8'h0D) begin
              tx_data_q <= 8'h0A;
            end else begin
              state_q    <= DONE;
              tx_valid_q <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
`endif

        DONE: begin
          state_q     <= IDLE;
          res_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end

        default: begin
          state_q     <= IDLE;
          res_ready_q <= 1'b1;
          tx_valid_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign res_ready = res_ready_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_hex_ascii_streamer.sv
// ---------------------------------------------------------------------------
// tb_hex_ascii_streamer
//
// Directed bench for hex_ascii_streamer. Instance u_dut is DATA_W=32 upper
// case; instance u_dut_lc is DATA_W=16 lower case. A vector table covers the
// plain frames; hand-written sequences cover backpressure, a result held
// during a frame, a mid-frame reset and lower case. Expected CR/LF are
// appended when HEX_ASCII_STREAMER_CRLF_EN is defined.
// ---------------------------------------------------------------------------
module tb_hex_ascii_streamer;

`ifdef HEX_ASCII_STREAMER_CRLF_EN
  localparam int CRLF = 1;
`else
  localparam int CRLF = 0;
`endif

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        res_valid = 1'b0;
  logic [31:0] res_data = '0;
  logic        suppress_lz = 1'b0;
  logic        tx_ready = 1'b1;
  logic        res_ready, tx_valid, busy, done;
  logic [7:0]  tx_data;

  logic        b_res_valid = 1'b0;
  logic [15:0] b_res_data = '0;
  logic        b_res_ready, b_tx_valid, b_busy, b_done;
  logic [7:0]  b_tx_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hex_ascii_streamer #(.DATA_W(32), .LOWER_CASE(0)) u_dut (
    .clk(clk), .n_rst(n_rst),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .suppress_lz(suppress_lz),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  hex_ascii_streamer #(.DATA_W(16), .LOWER_CASE(1)) u_dut_lc (
    .clk(clk), .n_rst(n_rst),
    .res_valid(b_res_valid), .res_data(b_res_data), .res_ready(b_res_ready),
    .suppress_lz(suppress_lz),
    .tx_valid(b_tx_valid), .tx_data(b_tx_data), .tx_ready(tx_ready),
    .busy(b_busy), .done(b_done)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        sup;
    logic [3:0]  n;      // number of digits expected
    logic [79:0] chars;  // expected digits, right-aligned, first char highest
    logic [3:0]  lat;    // cycles from accept to first tx_valid
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_char(input logic [79:0] chars, input int n, input int i);
    if (i < n) return chars[8*(n-1-i) +: 8];
    if (i == n) return 8'h0D;
    return 8'h0A;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge.
  task automatic run_frame(input logic [31:0] data, input logic sup, input int n,
                           input logic [79:0] chars, input int lat,
                           input int stall_idx, input int stall_len,
                           input logic hold, input logic [31:0] hold_data,
                           input logic hold_sup, input int abort_after,
                           input string tag);
    int ntot = n + 2 * CRLF;
    int idx = 0;
    int stalled = 0;
    int cyc = 0;
    bit started = 0, fin = 0, rdy_ok = 1, busy_ok = 1, gap = 0;
    check({tag, " accept_ready"}, 64'(res_ready), 64'd1);
    res_valid = 1'b1; res_data = data; suppress_lz = sup; tx_ready = 1'b1;
    @(posedge clk); #1;
    if (hold) begin
      res_data = hold_data; suppress_lz = hold_sup;
    end else begin
      // Post-accept changes must not disturb the frame.
      res_valid = 1'b0; res_data = ~data; suppress_lz = ~sup;
    end
    while (!fin && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        fin = 1;
      end else begin
        if (res_ready) rdy_ok = 0;
        if (!busy) busy_ok = 0;
        if (tx_valid) begin
          if (!started) begin
            started = 1;
            check({tag, " latency"}, 64'(cyc), 64'(lat));
          end
          if (idx >= ntot) begin
            tx_ready = 1'b1;
            idx++;
          end else if (idx == stall_idx && stalled < stall_len) begin
            tx_ready = 1'b0;
            stalled++;
            check({tag, " bp_hold"}, 64'(tx_data), 64'(exp_char(chars, n, idx)));
          end else begin
            tx_ready = 1'b1;
            check($sformatf("%s char%0d", tag, idx), 64'(tx_data), 64'(exp_char(chars, n, idx)));
            idx++;
            if (abort_after != 0 && idx == abort_after) begin
              @(posedge clk); #1 n_rst = 1'b0;
              #1;
              check({tag, " rst_tx_valid"},  64'(tx_valid),  64'd0);
              check({tag, " rst_busy"},      64'(busy),      64'd0);
              check({tag, " rst_res_ready"}, 64'(res_ready), 64'd1);
              check({tag, " rst_done"},      64'(done),      64'd0);
              @(negedge clk);
              n_rst = 1'b1;
              return;
            end
          end
        end else if (started && idx < ntot) begin
          gap = 1;
        end
      end
    end
    check({tag, " done_seen"},    64'(fin),      64'd1);
    check({tag, " char_count"},   64'(idx),      64'(ntot));
    check({tag, " valid_at_done"},64'(tx_valid), 64'd0);
    check({tag, " ready_low"},    64'(rdy_ok),   64'd1);
    check({tag, " busy_high"},    64'(busy_ok),  64'd1);
    check({tag, " no_gap"},       64'(gap),      64'd0);
    @(negedge clk);
    check({tag, " done_pulse"},   64'(done),      64'd0);
    check({tag, " idle_ready"},   64'(res_ready), 64'd1);
    check({tag, " idle_busy"},    64'(busy),      64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h12AB00F0, 1'b0, 4'd8, 80'h3132414230304630, 4'd1};
    vecs[1] = '{32'h000000F0, 1'b1, 4'd2, 80'h4630,             4'd8};
    vecs[2] = '{32'h00000000, 1'b1, 4'd1, 80'h30,               4'd9};
    vecs[3] = '{32'h00000001, 1'b1, 4'd1, 80'h31,               4'd9};
    vecs[4] = '{32'hFFFFFFFF, 1'b1, 4'd8, 80'h4646464646464646, 4'd2};
    vecs[5] = '{32'h00000000, 1'b0, 4'd8, 80'h3030303030303030, 4'd1};
    vecs[6] = '{32'h0A000000, 1'b1, 4'd7, 80'h41303030303030,   4'd3};

    repeat (3) @(negedge clk);
    check("reset res_ready", 64'(res_ready), 64'd1);
    check("reset tx_valid",  64'(tx_valid),  64'd0);
    check("reset tx_data",   64'(tx_data),   64'h00);
    check("reset busy",      64'(busy),      64'd0);
    check("reset done",      64'(done),      64'd0);
    n_rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].data, vecs[i].sup, int'(vecs[i].n), vecs[i].chars,
                int'(vecs[i].lat), -1, 0, 1'b0, 32'h0, 1'b0, 0,
                $sformatf("vec%0d", i));
    end

    // Five-cycle stall on the third character of DEADBEEF.
    run_frame(32'hDEADBEEF, 1'b0, 8, 80'h4445414442454546, 1, 2, 5,
              1'b0, 32'h0, 1'b0, 0, "backpressure");

    // A second result held through the frame is only taken back in IDLE.
    run_frame(32'h00000001, 1'b1, 1, 80'h31, 9, -1, 0,
              1'b1, 32'h12AB00F0, 1'b0, 0, "held_first");
    run_frame(32'h12AB00F0, 1'b0, 8, 80'h3132414230304630, 1, -1, 0,
              1'b0, 32'h0, 1'b0, 0, "held_second");

    // Reset after the third character, then a suppressed single digit.
    run_frame(32'h12345678, 1'b0, 8, 80'h3132333435363738, 1, -1, 0,
              1'b0, 32'h0, 1'b0, 3, "abort");
    run_frame(32'h0000000A, 1'b1, 1, 80'h41, 9, -1, 0,
              1'b0, 32'h0, 1'b0, 0, "after_rst");

    // Lower-case 16-bit instance.
    begin
      logic [79:0] lc_chars = 80'h62656566;
      int nb = 4 + 2 * CRLF;
      int bi = 0;
      bit bfin = 0;
      check("lc accept_ready", 64'(b_res_ready), 64'd1);
      b_res_valid = 1'b1; b_res_data = 16'hBEEF; suppress_lz = 1'b0; tx_ready = 1'b1;
      @(posedge clk); #1;
      b_res_valid = 1'b0; b_res_data = 16'h0000;
      for (int c = 0; c < 30 && !bfin; c++) begin
        @(negedge clk);
        if (b_done) begin
          bfin = 1;
        end else if (b_tx_valid) begin
          if (bi < nb)
            check($sformatf("lc char%0d", bi), 64'(b_tx_data), 64'(exp_char(lc_chars, 4, bi)));
          bi++;
        end
      end
      check("lc done_seen",  64'(bfin), 64'd1);
      check("lc char_count", 64'(bi),   64'(nb));
      @(negedge clk);
      check("lc idle_busy",  64'(b_busy), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
